// File: rtl/arkhe_pkg.sv
// arkhe_pkg: shared types, constants and estimate scaling for the arkhe noise engine and estimator
//   amp_t        18-bit signed amplitude
//   ATTEN_COEF   T1 attenuation coefficient (Q15, just under 1.0)
//   ATTEN_SHIFT  fractional bits of ATTEN_COEF
//   EST_W        width of the threshold-domain estimates
//   est_state_e  estimator FSM states
package arkhe_pkg;
    typedef logic signed [17:0] amp_t;
    localparam amp_t ATTEN_COEF = 18'sh7FFF;
    localparam int ATTEN_SHIFT = 15;
    localparam int EST_W = 16;
    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, REPORT} est_state_e;
    // Scales a hit count into the threshold domain; a full window (2**EST_W) saturates to all-ones
    function automatic logic [EST_W-1:0] scale_est(input logic [EST_W:0] hits, input int unsigned sh);
        logic [EST_W:0] s;
        s = hits << sh;
        return s[EST_W] ? '1 : s[EST_W-1:0];
    endfunction
endpackage

// File: rtl/arkhe_decoh_classifier.sv
// arkhe_decoh_classifier: 2-stage valid-tagged pipeline classifying (reference, degraded) pairs
//   clk, rst_n       clock, synchronous active-low reset
//   in_accept        a sample pair is consumed this cycle
//   ref_re/ref_im    reference amplitude
//   deg_re/deg_im    degraded amplitude
//   damp_hit         T1 attenuation detected (valid with hit_valid)
//   flip_hit         T2 phase flip detected (valid with hit_valid)
//   hit_valid        stage-2 result valid
//   pipe_busy        stage 1 holds a sample not yet classified
module arkhe_decoh_classifier
    import arkhe_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic in_accept,
    input  amp_t ref_re,
    input  amp_t ref_im,
    input  amp_t deg_re,
    input  amp_t deg_im,
    output logic damp_hit,
    output logic flip_hit,
    output logic hit_valid,
    output logic pipe_busy
);
    logic signed [35:0] p_re, p_im;
    amp_t r_re, r_im, d_re, d_im, a_re, a_im;
    logic signed [18:0] di, ri, ai;
    logic v1, damp_c, flip_c;

    assign p_re = 36'(ref_re) * 36'(ATTEN_COEF);
    assign p_im = 36'(ref_im) * 36'(ATTEN_COEF);
    // Widened to 19 bits so negating or taking |x| of the most negative amplitude cannot wrap
    assign di = d_im;
    assign ri = r_im;
    assign ai = a_im;
    assign damp_c = (d_re == a_re && a_re != r_re) ||
                    (((di < 0) ? -di : di) == ((ai < 0) ? -ai : ai) && a_im != r_im);
    assign flip_c = r_im != 0 && (di == -ri || di == -ai);
    assign pipe_busy = v1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            hit_valid <= 1'b0;
            damp_hit <= 1'b0;
            flip_hit <= 1'b0;
        end else begin
            v1 <= in_accept;
            hit_valid <= v1;
            damp_hit <= v1 & damp_c;
            flip_hit <= v1 & flip_c;
        end
        if (in_accept) begin
            r_re <= ref_re;
            r_im <= ref_im;
            d_re <= deg_re;
            d_im <= deg_im;
            a_re <= amp_t'(p_re >>> ATTEN_SHIFT);
            a_im <= amp_t'(p_im >>> ATTEN_SHIFT);
        end
    end
endmodule

// File: rtl/arkhe_decoherence_estimator.sv
// arkhe_decoherence_estimator: windowed T1/T2 hit counter reporting threshold-domain estimates
//   clk, rst_n             clock, synchronous active-low reset
//   start                  begin a window (IDLE only)
//   in_valid / in_ready    sample pair handshake
//   ref_re..deg_im         reference and degraded amplitudes
//   est_valid / est_ready  estimate handshake
//   t1_est, t2_est         damping / dephasing estimates
//   busy                   FSM not idle
module arkhe_decoherence_estimator
    import arkhe_pkg::*;
#(
    parameter int WIN_LOG2 = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  amp_t             ref_re,
    input  amp_t             ref_im,
    input  amp_t             deg_re,
    input  amp_t             deg_im,
    output logic             est_valid,
    input  logic             est_ready,
    output logic [EST_W-1:0] t1_est,
    output logic [EST_W-1:0] t2_est,
    output logic             busy
);
    localparam int CW = WIN_LOG2 + 1;
    localparam logic [CW-1:0] LAST = CW'((1 << WIN_LOG2) - 1);
    est_state_e state;
    logic [CW-1:0] cnt, hit1, hit2, h1_nxt, h2_nxt;
    logic accept, damp_hit, flip_hit, hit_valid, pipe_busy;

    assign accept = in_valid & in_ready;
    assign h1_nxt = hit1 + CW'(hit_valid & damp_hit);
    assign h2_nxt = hit2 + CW'(hit_valid & flip_hit);

    arkhe_decoh_classifier u_cls (
        .clk(clk), .rst_n(rst_n), .in_accept(accept),
        .ref_re(ref_re), .ref_im(ref_im), .deg_re(deg_re), .deg_im(deg_im),
        .damp_hit(damp_hit), .flip_hit(flip_hit), .hit_valid(hit_valid), .pipe_busy(pipe_busy)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            in_ready <= 1'b0;
            est_valid <= 1'b0;
            busy <= 1'b0;
            t1_est <= '0;
            t2_est <= '0;
            cnt <= '0;
            hit1 <= '0;
            hit2 <= '0;
        end else begin
            hit1 <= h1_nxt;
            hit2 <= h2_nxt;
            case (state)
                IDLE: if (start) begin
                    state <= ACCUM;
                    in_ready <= 1'b1;
                    busy <= 1'b1;
                    cnt <= '0;
                    hit1 <= '0;
                    hit2 <= '0;
                end
                ACCUM: if (accept) begin
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state <= DRAIN;
                        in_ready <= 1'b0;
                    end
                end
                // Stage 1 empty: the final hit sits in stage 2 and is folded in via h*_nxt
                DRAIN: if (!pipe_busy) begin
                    state <= REPORT;
                    est_valid <= 1'b1;
                    t1_est <= scale_est((EST_W+1)'(h1_nxt), EST_W - WIN_LOG2);
                    t2_est <= scale_est((EST_W+1)'(h2_nxt), EST_W - WIN_LOG2);
                end
                REPORT: if (est_ready) begin
                    state <= IDLE;
                    est_valid <= 1'b0;
                    busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_arkhe_decoherence_estimator.sv
// tb_arkhe_decoherence_estimator: scoreboard bench for the decoherence estimator (N=16)
module tb_arkhe_decoherence_estimator;
    import arkhe_pkg::*;

    logic clk = 0, rst_n = 0, start = 0, in_valid = 0, est_ready = 0;
    amp_t ref_re = 0, ref_im = 0, deg_re = 0, deg_im = 0;
    logic in_ready, est_valid, busy;
    logic [15:0] t1_est, t2_est;

    typedef struct {logic [15:0] t1; logic [15:0] t2;} exp_t;
    exp_t sb[$];
    int n_cmp = 0, n_fail = 0;

    always #5 clk = ~clk;

    arkhe_decoherence_estimator #(.WIN_LOG2(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .ref_re(ref_re), .ref_im(ref_im), .deg_re(deg_re), .deg_im(deg_im),
        .est_valid(est_valid), .est_ready(est_ready), .t1_est(t1_est), .t2_est(t2_est), .busy(busy)
    );

    function automatic logic [15:0] scaled(input int n);
        return n >= 16 ? 16'hFFFF : 16'(n * 4096);
    endfunction

    task automatic pulse_start;
        start = 1;
        @(negedge clk);
        start = 0;
    endtask

    // First n_hit pairs use (hre,him) as degraded value, the rest (mre,mim); expected hit counts are given
    task automatic send_window(input int n_hit, input amp_t rre, rim, hre, him, mre, mim, input int e1, e2);
        pulse_start();
        for (int i = 0; i < 16; i++) begin
            in_valid = 1;
            ref_re = rre;
            ref_im = rim;
            deg_re = (i < n_hit) ? hre : mre;
            deg_im = (i < n_hit) ? him : mim;
            @(negedge clk);
        end
        in_valid = 0;
        sb.push_back('{scaled(e1), scaled(e2)});
    endtask

    task automatic wait_est(output bit got);
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (est_valid === 1'b1) got = 1;
            else @(negedge clk);
        end
    endtask

    task automatic ack;
        est_ready = 1;
        @(negedge clk);
        est_ready = 0;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        n_cmp += 5;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        if (est_valid !== 1'b0) begin n_fail++; $display("FAIL reset_est_valid: got %b expected 0", est_valid); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (t1_est !== 16'h0) begin n_fail++; $display("FAIL reset_t1: got %h expected 0000", t1_est); end
        if (t2_est !== 16'h0) begin n_fail++; $display("FAIL reset_t2: got %h expected 0000", t2_est); end
    endtask

    task automatic test_clean;
        exp_t e;
        send_window(0, 1000, 500, 1000, 500, 1000, 500, 0, 0);
        n_cmp += 3;
        if (est_valid !== 1'b0) begin n_fail++; $display("FAIL clean_lat0: got %b expected 0", est_valid); end
        @(negedge clk);
        if (est_valid !== 1'b0) begin n_fail++; $display("FAIL clean_lat1: got %b expected 0", est_valid); end
        @(negedge clk);
        if (est_valid !== 1'b1) begin n_fail++; $display("FAIL clean_lat2: got %b expected 1", est_valid); end
        e = sb.pop_front();
        n_cmp += 2;
        if (t1_est !== e.t1) begin n_fail++; $display("FAIL clean_t1: got %h expected %h", t1_est, e.t1); end
        if (t2_est !== e.t2) begin n_fail++; $display("FAIL clean_t2: got %h expected %h", t2_est, e.t2); end
        ack();
        n_cmp += 2;
        if (est_valid !== 1'b0) begin n_fail++; $display("FAIL clean_fall: got %b expected 0", est_valid); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL clean_idle: got %b expected 0", busy); end
    endtask

    task automatic test_damp;
        exp_t e;
        bit got;
        send_window(4, 1000, 500, 999, 500, 1000, 500, 4, 0);
        send_window_done: begin end
        wait_est(got);
        e = sb.pop_front();
        n_cmp += 3;
        if (!got) begin n_fail++; $display("FAIL damp4_timeout: got no est_valid expected est_valid"); end
        if (t1_est !== e.t1) begin n_fail++; $display("FAIL damp4_t1: got %h expected %h", t1_est, e.t1); end
        if (t2_est !== e.t2) begin n_fail++; $display("FAIL damp4_t2: got %h expected %h", t2_est, e.t2); end
        ack();
        send_window(16, 1000, 500, 999, 500, 999, 500, 16, 0);
        wait_est(got);
        e = sb.pop_front();
        n_cmp += 3;
        if (!got) begin n_fail++; $display("FAIL damp16_timeout: got no est_valid expected est_valid"); end
        if (t1_est !== e.t1) begin n_fail++; $display("FAIL damp16_t1: got %h expected %h", t1_est, e.t1); end
        if (t2_est !== e.t2) begin n_fail++; $display("FAIL damp16_t2: got %h expected %h", t2_est, e.t2); end
        ack();
    endtask

    task automatic test_flip;
        exp_t e;
        bit got;
        send_window(8, 1000, 500, 1000, -500, 1000, 500, 0, 8);
        wait_est(got);
        e = sb.pop_front();
        n_cmp += 3;
        if (!got) begin n_fail++; $display("FAIL flip8_timeout: got no est_valid expected est_valid"); end
        if (t1_est !== e.t1) begin n_fail++; $display("FAIL flip8_t1: got %h expected %h", t1_est, e.t1); end
        if (t2_est !== e.t2) begin n_fail++; $display("FAIL flip8_t2: got %h expected %h", t2_est, e.t2); end
        ack();
        // deg_re attenuated and deg_im flipped: both hits in the same sample
        send_window(3, 1000, 500, 999, -500, 1000, 500, 3, 3);
        wait_est(got);
        e = sb.pop_front();
        n_cmp += 3;
        if (!got) begin n_fail++; $display("FAIL both3_timeout: got no est_valid expected est_valid"); end
        if (t1_est !== e.t1) begin n_fail++; $display("FAIL both3_t1: got %h expected %h", t1_est, e.t1); end
        if (t2_est !== e.t2) begin n_fail++; $display("FAIL both3_t2: got %h expected %h", t2_est, e.t2); end
        ack();
    endtask

    task automatic test_ambiguous;
        exp_t e;
        bit got;
        pulse_start();
        for (int i = 0; i < 16; i++) begin
            in_valid = 1;
            ref_re = 0;
            ref_im = 0;
            deg_re = amp_t'($urandom);
            deg_im = amp_t'($urandom);
            @(negedge clk);
        end
        in_valid = 0;
        sb.push_back('{scaled(0), scaled(0)});
        wait_est(got);
        e = sb.pop_front();
        n_cmp += 3;
        if (!got) begin n_fail++; $display("FAIL ambig_timeout: got no est_valid expected est_valid"); end
        if (t1_est !== e.t1) begin n_fail++; $display("FAIL ambig_t1: got %h expected %h", t1_est, e.t1); end
        if (t2_est !== e.t2) begin n_fail++; $display("FAIL ambig_t2: got %h expected %h", t2_est, e.t2); end
        ack();
    endtask

    task automatic test_hold;
        exp_t e;
        bit got;
        send_window(5, 1000, 500, 999, 500, 1000, 500, 5, 0);
        wait_est(got);
        e = sb.pop_front();
        n_cmp++;
        if (!got) begin n_fail++; $display("FAIL hold_timeout: got no est_valid expected est_valid"); end
        for (int i = 0; i < 10; i++) begin
            start = 1;
            in_valid = 1;
            @(negedge clk);
            n_cmp += 4;
            if (est_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid[%0d]: got %b expected 1", i, est_valid); end
            if (t1_est !== e.t1) begin n_fail++; $display("FAIL hold_t1[%0d]: got %h expected %h", i, t1_est, e.t1); end
            if (t2_est !== e.t2) begin n_fail++; $display("FAIL hold_t2[%0d]: got %h expected %h", i, t2_est, e.t2); end
            if (in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_in_ready[%0d]: got %b expected 0", i, in_ready); end
        end
        in_valid = 0;
        est_ready = 1;
        @(negedge clk);
        start = 0;
        est_ready = 0;
        @(negedge clk);
        n_cmp += 4;
        if (est_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_valid: got %b expected 0", est_valid); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy: got %b expected 0", busy); end
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_in_ready: got %b expected 0", in_ready); end
        if (t1_est !== e.t1) begin n_fail++; $display("FAIL idle_retain_t1: got %h expected %h", t1_est, e.t1); end
    endtask

    task automatic test_reset_mid;
        exp_t e;
        bit got;
        pulse_start();
        for (int i = 0; i < 7; i++) begin
            in_valid = 1;
            ref_re = 1000;
            ref_im = 500;
            deg_re = 999;
            deg_im = 500;
            @(negedge clk);
        end
        in_valid = 0;
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        n_cmp += 5;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b expected 0", busy); end
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_in_ready: got %b expected 0", in_ready); end
        if (est_valid !== 1'b0) begin n_fail++; $display("FAIL mid_est_valid: got %b expected 0", est_valid); end
        if (t1_est !== 16'h0) begin n_fail++; $display("FAIL mid_t1: got %h expected 0000", t1_est); end
        if (t2_est !== 16'h0) begin n_fail++; $display("FAIL mid_t2: got %h expected 0000", t2_est); end
        send_window(2, 1000, 500, 999, 500, 1000, 500, 2, 0);
        wait_est(got);
        e = sb.pop_front();
        n_cmp += 3;
        if (!got) begin n_fail++; $display("FAIL mid2_timeout: got no est_valid expected est_valid"); end
        if (t1_est !== e.t1) begin n_fail++; $display("FAIL mid2_t1: got %h expected %h", t1_est, e.t1); end
        if (t2_est !== e.t2) begin n_fail++; $display("FAIL mid2_t2: got %h expected %h", t2_est, e.t2); end
        ack();
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_clean();
        test_damp();
        test_flip();
        test_ambiguous();
        test_hold();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
